mar_gen: RTL and testbench

Parametrised memory address register for the FPGAComputer datapath. It holds the RAM address and loads it from one of three sources: the shared bus, the front-panel programmer (PRGM/PRGM_IN), or an auto-increment. Address width, bus width, field position and upper address limit are all parameters. Over the fixed 4-bit MAR it adds:
- a synchronised programmer strobe with a pending latch,
- halt-freeze,
- wrap detection,
- out-of-range rejection.

---
 rtl/mar_gen_if.sv | 28 ++
 rtl/mar_gen.sv | 132 +++++++++++++
 tb/tb_mar_gen.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mar_gen_if.sv
// mar_gen_if: request/response bundle between the datapath and the memory
// address register. Control and data requests travel from master to slave.
// The registered address and status travel back from slave to master.
interface mar_gen_if #(
   parameter int ADDR_W = 4,
   parameter int BUS_W  = 8
);
   logic              HLT;
   logic              PRGM;
   logic [BUS_W-1:0]  PRGM_IN;
   logic              LD;
   logic [BUS_W-1:0]  BUS_IN;
   logic              INC;
   logic [ADDR_W-1:0] ADDR;
   logic              WRAP;
   logic              OOR;
   logic [1:0]        SRC;

   modport master (
      output HLT, PRGM, PRGM_IN, LD, BUS_IN, INC,
      input  ADDR, WRAP, OOR, SRC
   );

   modport slave (
      input  HLT, PRGM, PRGM_IN, LD, BUS_IN, INC,
      output ADDR, WRAP, OOR, SRC
   );
endinterface

// File: rtl/mar_gen.sv
// mar_gen: memory address register with three load sources.
// - The shared bus loads the register when LD is high.
// - The front-panel programmer loads it on a synchronised PRGM strobe, or
//   later from a pending latch if the computer is halted.
// - INC increments the address and wraps to 0 after LIMIT.
// Loads above LIMIT are rejected and flagged on the sticky OOR output.
// All outputs come straight from flops.
module mar_gen #(
   parameter int ADDR_W   = 4,
   parameter int BUS_W    = 8,
   parameter int ADDR_LSB = 0,
   parameter int LIMIT    = (1 << ADDR_W) - 1
) (
   input  logic        CLK,
   input  logic        RESET,
   mar_gen_if.slave    bus
);

   localparam logic [ADDR_W-1:0] LIMIT_V = LIMIT[ADDR_W-1:0];

   localparam logic [1:0] SRC_RESET = 2'b00;
   localparam logic [1:0] SRC_BUS   = 2'b01;
   localparam logic [1:0] SRC_PRGM  = 2'b10;
   localparam logic [1:0] SRC_INC   = 2'b11;

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_PEND = 1'b1
   } state_t;

   // Address field extraction from a bus-width word
   function automatic logic [ADDR_W-1:0] fld(input logic [BUS_W-1:0] x);
      return x[ADDR_LSB +: ADDR_W];
   endfunction

   // A load value is acceptable only up to the configured upper limit
   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return (a <= LIMIT_V);
   endfunction

   state_t            state_r;
   logic              p_meta_r;
   logic              p_sync_r;
   logic              p_prev_r;
   logic [ADDR_W-1:0] addr_r;
   logic [1:0]        src_r;
   logic              wrap_r;
   logic              oor_r;

   logic              strobe_s;
   logic [ADDR_W-1:0] prgm_fld_s;
   logic [ADDR_W-1:0] bus_fld_s;

   // Rising-edge detect on the synchronised programmer strobe, plus field taps
   always_comb begin
      strobe_s   = p_sync_r & ~p_prev_r;
      prgm_fld_s = fld(bus.PRGM_IN);
      bus_fld_s  = fld(bus.BUS_IN);
   end

   // Two-flop synchroniser for PRGM followed by a delayed copy for edge detect
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         p_meta_r <= 1'b0;
         p_sync_r <= 1'b0;
         p_prev_r <= 1'b0;
      end else begin
         p_meta_r <= bus.PRGM;
         p_sync_r <= p_meta_r;
         p_prev_r <= p_sync_r;
      end
   end

   // Pending-load FSM and address/status registers.
   // Priority when running: programmer, then bus load, then increment.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_r <= ST_RUN;
         addr_r  <= '0;
         src_r   <= SRC_RESET;
         wrap_r  <= 1'b0;
         oor_r   <= 1'b0;
      end else begin
         wrap_r <= 1'b0;
         if (bus.HLT) begin
            // Frozen: only remember that a programmer load is owed
            if (strobe_s) begin
               state_r <= ST_PEND;
            end else begin
               state_r <= state_r;
            end
         end else if (strobe_s || (state_r == ST_PEND)) begin
            // PRGM_IN is sampled now, so merged strobes use the latest data
            state_r <= ST_RUN;
            if (in_range(prgm_fld_s)) begin
               addr_r <= prgm_fld_s;
               src_r  <= SRC_PRGM;
               oor_r  <= 1'b0;
            end else begin
               oor_r  <= 1'b1;
            end
         end else if (bus.LD) begin
            state_r <= ST_RUN;
            if (in_range(bus_fld_s)) begin
               addr_r <= bus_fld_s;
               src_r  <= SRC_BUS;
               oor_r  <= 1'b0;
            end else begin
               oor_r  <= 1'b1;
            end
         end else if (bus.INC) begin
            state_r <= ST_RUN;
            src_r   <= SRC_INC;
            if (addr_r == LIMIT_V) begin
               addr_r <= '0;
               wrap_r <= 1'b1;
            end else begin
               addr_r <= addr_r + ADDR_W'(1);
            end
         end else begin
            state_r <= ST_RUN;
         end
      end
   end

   // Outputs are direct flop taps
   assign bus.ADDR = addr_r;
   assign bus.SRC  = src_r;
   assign bus.WRAP = wrap_r;
   assign bus.OOR  = oor_r;

endmodule

// File: tb/tb_mar_gen.sv
// tb_mar_gen: directed vectors with a scoreboard queue.
// Stimulus pushes the expected outputs for each clock edge.
// A negedge monitor pops and compares them against one of two DUTs:
// DUT 0 uses LIMIT=15 and DUT 1 uses LIMIT=11.
module tb_mar_gen;

   typedef struct {
      int         cyc;
      int         sel;
      logic [3:0] addr;
      logic [1:0] src;
      logic       wrap;
      logic       oor;
      string      name;
   } exp_t;

   logic CLK;
   logic RESET;
   int   cyc;
   int   tests_run;
   int   tests_failed;
   exp_t sb[$];

   mar_gen_if #(.ADDR_W(4), .BUS_W(8)) if0 ();
   mar_gen_if #(.ADDR_W(4), .BUS_W(8)) if1 ();

   mar_gen #(.ADDR_W(4), .BUS_W(8), .ADDR_LSB(0), .LIMIT(15)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (if0.slave)
   );

   mar_gen #(.ADDR_W(4), .BUS_W(8), .ADDR_LSB(0), .LIMIT(11)) dut_l (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (if1.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // Wait for the next active edge and move just past it
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Record the outputs expected after the edge just taken
   task automatic expect_now(input int sel, input logic [3:0] a, input logic [1:0] s,
                             input logic w, input logic o, input string name);
      exp_t e;
      e.cyc  = cyc;
      e.sel  = sel;
      e.addr = a;
      e.src  = s;
      e.wrap = w;
      e.oor  = o;
      e.name = name;
      sb.push_back(e);
   endtask

   // Monitor: compare DUT outputs with queued expectations on the falling edge
   always @(negedge CLK) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         exp_t       e;
         logic [3:0] a;
         logic [1:0] s;
         logic       w;
         logic       o;
         e = sb.pop_front();
         if (e.sel == 1) begin
            a = if1.ADDR; s = if1.SRC; w = if1.WRAP; o = if1.OOR;
         end else begin
            a = if0.ADDR; s = if0.SRC; w = if0.WRAP; o = if0.OOR;
         end
         tests_run = tests_run + 1;
         if (a !== e.addr || s !== e.src || w !== e.wrap || o !== e.oor) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s (cyc %0d): got addr=%0d src=%b wrap=%b oor=%b, want addr=%0d src=%b wrap=%b oor=%b",
                     e.name, cyc, a, s, w, o, e.addr, e.src, e.wrap, e.oor);
         end
      end
   end

   // Safety net against a hung run
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      RESET = 1'b0;
      if0.HLT = 1'b0; if0.PRGM = 1'b1; if0.PRGM_IN = 8'h06;
      if0.LD  = 1'b1; if0.BUS_IN = 8'h05; if0.INC = 1'b1;
      if1.HLT = 1'b0; if1.PRGM = 1'b0; if1.PRGM_IN = 8'h00;
      if1.LD  = 1'b0; if1.BUS_IN = 8'h00; if1.INC = 1'b0;

      // Reset held with every request active
      step(); expect_now(0, 4'd0, 2'b00, 1'b0, 1'b0, "reset_e1");
      step(); expect_now(0, 4'd0, 2'b00, 1'b0, 1'b0, "reset_e2");
      if0.PRGM = 1'b0; if0.LD = 1'b0; if0.INC = 1'b0;
      RESET = 1'b1;
      step(); expect_now(0, 4'd0, 2'b00, 1'b0, 1'b0, "post_reset_e1");
      step(); expect_now(0, 4'd0, 2'b00, 1'b0, 1'b0, "post_reset_e2");

      // Programmer load: lands on the third edge after PRGM rises
      if0.PRGM_IN = 8'h05; if0.PRGM = 1'b1;
      step(); expect_now(0, 4'd0, 2'b00, 1'b0, 1'b0, "prgm_e1");
      step(); expect_now(0, 4'd0, 2'b00, 1'b0, 1'b0, "prgm_e2");
      step(); expect_now(0, 4'd5, 2'b10, 1'b0, 1'b0, "prgm_e3_load");
      // PRGM still high: a bus load must stick and no second programmer load follows
      if0.LD = 1'b1; if0.BUS_IN = 8'h01;
      step(); expect_now(0, 4'd1, 2'b01, 1'b0, 1'b0, "prgm_held_ld");
      if0.LD = 1'b0;
      step(); expect_now(0, 4'd1, 2'b01, 1'b0, 1'b0, "prgm_single_load");
      if0.PRGM = 1'b0;
      step(); step();
      if0.PRGM_IN = 8'h0A; if0.PRGM = 1'b1;
      step(); step();
      step(); expect_now(0, 4'd10, 2'b10, 1'b0, 1'b0, "prgm_second_load");
      if0.PRGM = 1'b0;
      step(); step();

      // Priority on a single edge
      if0.LD = 1'b1; if0.BUS_IN = 8'h03;
      step(); expect_now(0, 4'd3, 2'b01, 1'b0, 1'b0, "ld_3");
      if0.BUS_IN = 8'h07; if0.INC = 1'b1;
      step(); expect_now(0, 4'd7, 2'b01, 1'b0, 1'b0, "ld_beats_inc");
      if0.LD = 1'b0;
      step(); expect_now(0, 4'd8, 2'b11, 1'b0, 1'b0, "inc_alone");
      if0.INC = 1'b0;
      if0.PRGM_IN = 8'h0C; if0.PRGM = 1'b1;
      step(); expect_now(0, 4'd8, 2'b11, 1'b0, 1'b0, "prio_prgm_e1");
      step(); expect_now(0, 4'd8, 2'b11, 1'b0, 1'b0, "prio_prgm_e2");
      if0.LD = 1'b1; if0.BUS_IN = 8'h02;
      step(); expect_now(0, 4'd12, 2'b10, 1'b0, 1'b0, "prgm_beats_ld");
      if0.LD = 1'b0; if0.PRGM = 1'b0;
      step(); expect_now(0, 4'd12, 2'b10, 1'b0, 1'b0, "ld_dropped");
      step();

      // Wrap at LIMIT=15
      if0.LD = 1'b1; if0.BUS_IN = 8'h0E;
      step(); expect_now(0, 4'd14, 2'b01, 1'b0, 1'b0, "wrap_load_14");
      if0.LD = 1'b0; if0.INC = 1'b1;
      step(); expect_now(0, 4'd15, 2'b11, 1'b0, 1'b0, "wrap_inc_15");
      step(); expect_now(0, 4'd0,  2'b11, 1'b1, 1'b0, "wrap_inc_0");
      step(); expect_now(0, 4'd1,  2'b11, 1'b0, 1'b0, "wrap_inc_1");
      if0.INC = 1'b0;
      step(); expect_now(0, 4'd1,  2'b11, 1'b0, 1'b0, "wrap_hold");

      // Halt with a pending programmer load; LD and INC are ignored
      if0.HLT = 1'b1; if0.PRGM_IN = 8'h09; if0.PRGM = 1'b1;
      if0.LD = 1'b1; if0.BUS_IN = 8'h03; if0.INC = 1'b1;
      step(); expect_now(0, 4'd1, 2'b11, 1'b0, 1'b0, "hlt_e1");
      step(); expect_now(0, 4'd1, 2'b11, 1'b0, 1'b0, "hlt_e2");
      step(); expect_now(0, 4'd1, 2'b11, 1'b0, 1'b0, "hlt_strobe");
      if0.PRGM = 1'b0;
      step(); expect_now(0, 4'd1, 2'b11, 1'b0, 1'b0, "hlt_pend_e4");
      if0.LD = 1'b0; if0.INC = 1'b0;
      step(); expect_now(0, 4'd1, 2'b11, 1'b0, 1'b0, "hlt_pend_e5");
      if0.HLT = 1'b0;
      step(); expect_now(0, 4'd9, 2'b10, 1'b0, 1'b0, "pend_exec");
      if0.LD = 1'b1; if0.BUS_IN = 8'h04;
      step(); expect_now(0, 4'd4, 2'b01, 1'b0, 1'b0, "pend_cleared");
      if0.LD = 1'b0;
      step();

      // Reset while a load is pending discards it
      if0.HLT = 1'b1; if0.PRGM_IN = 8'h07; if0.PRGM = 1'b1;
      step(); step(); step();
      if0.PRGM = 1'b0; RESET = 1'b0;
      #1;
      tests_run = tests_run + 1;
      if (if0.ADDR !== 4'd0 || if0.SRC !== 2'b00) begin
         tests_failed = tests_failed + 1;
         $display("FAIL async_reset: got addr=%0d src=%b, want addr=0 src=00", if0.ADDR, if0.SRC);
      end
      step(); expect_now(0, 4'd0, 2'b00, 1'b0, 1'b0, "rst_pend_e1");
      RESET = 1'b1; if0.HLT = 1'b0;
      step(); expect_now(0, 4'd0, 2'b00, 1'b0, 1'b0, "rst_pend_e2");
      step(); expect_now(0, 4'd0, 2'b00, 1'b0, 1'b0, "rst_pend_e3");
      step(); expect_now(0, 4'd0, 2'b00, 1'b0, 1'b0, "rst_pend_no_load");

      // Out of range on the LIMIT=11 instance
      if1.LD = 1'b1; if1.BUS_IN = 8'h04;
      step(); expect_now(1, 4'd4,  2'b01, 1'b0, 1'b0, "oor_ld_4");
      if1.BUS_IN = 8'h0D;
      step(); expect_now(1, 4'd4,  2'b01, 1'b0, 1'b1, "oor_ld_13_rejected");
      if1.BUS_IN = 8'h0B;
      step(); expect_now(1, 4'd11, 2'b01, 1'b0, 1'b0, "oor_ld_11_ok");
      if1.LD = 1'b0; if1.INC = 1'b1;
      step(); expect_now(1, 4'd0,  2'b11, 1'b1, 1'b0, "oor_inc_wrap");
      if1.INC = 1'b0;
      step(); expect_now(1, 4'd0,  2'b11, 1'b0, 1'b0, "oor_wrap_drop");
      if1.PRGM_IN = 8'h0E; if1.PRGM = 1'b1;
      step(); step();
      step(); expect_now(1, 4'd0,  2'b11, 1'b0, 1'b1, "oor_prgm_rejected");
      if1.PRGM = 1'b0;
      step(); expect_now(1, 4'd0,  2'b11, 1'b0, 1'b1, "oor_sticky");

      step(); step();
      tests_run = tests_run + 1;
      if (sb.size() != 0) begin
         tests_failed = tests_failed + 1;
         $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
